tick_rate_controller: RTL and testbench
=======================================

Name: tick_rate_controller

Overview:
- Programmable tick generator with a control front end.
- Owns a divide counter that emits one-cycle `tick` pulses every (P+1) cycles of `CLK_in`.
- Sequences the counter through idle, continuous-run and N-tick burst operation.
- Accepts period reconfiguration through a valid/ready handshake and applies it only at tick boundaries, so no interval is ever short or split. Game/LED logic (e.g. jackpot) consumes `tick` as its step enable.

Parameters:
- CNT_W, 32, width of the divide counter and period values.
- DEFAULT_PERIOD, 10000000, period P loaded at reset.
- BURST_W, 8, width of the burst length.

Ports:
- CLK_in  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cfg_valid  input  1  new period offered.
- cfg_period  input  CNT_W  offered period P.
- cfg_ready  output  1  high when the pending-config slot is empty.
- start  input  1  start request, one-cycle pulse or level.
- stop  input  1  stop request.
- burst_len  input  BURST_W  ticks per run; 0 = continuous.
- tick  output  1  one-cycle pulse, registered.
- running  output  1  high in the RUN state.
- burst_done  output  1  one-cycle pulse coincident with the final burst tick.
- period_active  output  CNT_W  period currently in use.

Behaviour:
- All logic is clocked on the `posedge CLK_in`. `reset` is synchronous and active-high, and has priority over every other input.
- Reset values:
  - Outputs: tick=0, running=0, burst_done=0, cfg_ready=1, period_active=DEFAULT_PERIOD.
  - Internal: count=0, pending slot empty, remaining=0, state IDLE.
- Reset asserted mid-run returns to IDLE on that edge and discards any pending config.
- States:
  - IDLE: counter held at 0, no ticks.
  - RUN: counter counts 0..P, then wraps to 0.
- IDLE->RUN: `start`=1 and `stop`=0 at an edge. On that edge count<=0, remaining<=burst_len, running<=1.
- RUN->IDLE occurs on either event:
  - `stop`=1 at any edge.
  - The final burst tick issued (remaining==1 at a tick edge).
- Tick timing:
  - In RUN, at the edge where count==period_active: tick<=1 and count<=0. Otherwise count<=count+1 and tick<=0.
  - Spacing between ticks is exactly P+1 cycles.
  - First tick is high during the cycle after edge k+P+1, where k is the edge that sampled `start`.
  - P=0 gives a tick every cycle while running.
- Burst counting (burst_len!=0): remaining decrements on each tick. The tick that takes remaining 1->0 also sets burst_done<=1 and moves the state to IDLE. The next cycle has running=0.
- Continuous mode (burst_len==0): remaining is ignored; the block runs until `stop`.
- Simultaneous events:
  - `stop` at a tick edge suppresses that tick and suppresses burst_done.
  - `start`+`stop` in IDLE: stop wins, state stays IDLE.
  - `start` in RUN is ignored; burst_len is not re-sampled.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. The period is captured into the pending slot and cfg_ready<=0.
  - In IDLE, pending is applied on the following edge: period_active updated, cfg_ready<=1.
  - In RUN, pending is applied at the next tick edge. The new P governs the interval starting at that edge; cfg_ready returns to 1 on the same edge.
  - While the slot is full, cfg_valid is ignored and the offered value is not lost; the requester holds it.
  - Pending config survives stop (it is applied in IDLE).
- Counter arithmetic is unsigned CNT_W-bit. Count never exceeds period_active, so there is no overflow.

Optional Feature:
- Macro: SQUARE_OUT_EN.
- When defined:
  - Adds output port `square_out` (1 bit), reset 0.
  - Toggles on every tick edge, giving a 50%-duty divided clock of period 2(P+1).
  - Forced to 0 on any transition to IDLE.
- When undefined: the port and its flop are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with P=3, burst_len=0 → ticks every 4 cycles; first tick 4 cycles after the start edge; running=1 throughout.
- P=2, burst_len=3, start → exactly 3 ticks 3 cycles apart; burst_done with the 3rd tick; running=0 on the next cycle; no further ticks.
- Running with P=5, cfg_period=1 accepted mid-interval → cfg_ready=0 until the next tick; that interval is still 6 cycles; subsequent intervals are 2 cycles; period_active=1.
- `stop` asserted exactly on a tick edge (P=4) → no tick that cycle; state IDLE; a second cfg_valid while the slot is full is not accepted (cfg_ready=0).
- `reset` asserted mid-burst with pending config → next cycle: all outputs at reset values, period_active=DEFAULT_PERIOD, cfg_ready=1.
- SQUARE_OUT_EN, P=1, continuous → square_out toggles every 2 cycles (period 4); returns to 0 after stop.

Source files
------------

// File: rtl/tick_rate_controller.sv
// Programmable tick generator: idle / continuous / N-tick burst sequencing with
// handshaked period reconfiguration applied only at tick boundaries.
// Optional divided-clock output enabled by defining SQUARE_OUT_EN.
module tick_rate_controller #(
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 10000000,
  parameter int          BURST_W        = 8
) (
  input  logic               CLK_in,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_period,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               running,
  output logic               burst_done,
`ifdef SQUARE_OUT_EN
  output logic               square_out,
`endif
  output logic [CNT_W-1:0]   period_active
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   pending;
  logic               pending_full;
  logic [BURST_W-1:0] remaining;

  logic tick_edge;
  logic final_tick;
  logic go;
  logic to_idle;
  logic apply_cfg;
  logic accept_cfg;

  // A stop on the would-be tick edge suppresses the tick and any burst completion.
  assign tick_edge  = (state == RUN) && !stop && (count == period_active);
  assign final_tick = tick_edge && (remaining == BURST_W'(1));
  assign go         = (state == IDLE) && (state_nxt == RUN);
  assign to_idle    = (state == RUN) && (state_nxt == IDLE);
  assign apply_cfg  = pending_full && ((state == IDLE) || tick_edge);
  assign accept_cfg = cfg_valid && !pending_full;

  assign cfg_ready = !pending_full;
  assign running   = (state == RUN);

  always_ff @(posedge CLK_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN:  if (stop || final_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (reset) begin
      count         <= '0;
      tick          <= 1'b0;
      burst_done    <= 1'b0;
      remaining     <= '0;
      pending       <= '0;
      pending_full  <= 1'b0;
      period_active <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      tick       <= tick_edge;
      burst_done <= final_tick;

      if ((state == RUN) && !stop && !tick_edge) count <= count + CNT_W'(1);
      else                                       count <= '0;

      if (go)                                     remaining <= burst_len;
      else if (tick_edge && (remaining != '0))    remaining <= remaining - BURST_W'(1);

      if (apply_cfg) period_active <= pending;

      // Accept and apply are mutually exclusive: accept needs an empty slot, apply a full one.
      if (accept_cfg) begin
        pending      <= cfg_period;
        pending_full <= 1'b1;
      end else if (apply_cfg) begin
        pending_full <= 1'b0;
      end
    end
  end

`ifdef SQUARE_OUT_EN
  always_ff @(posedge CLK_in) begin
    if (reset)          square_out <= 1'b0;
    else if (to_idle)   square_out <= 1'b0;
    else if (tick_edge) square_out <= !square_out;
  end
`endif

endmodule

// File: tb/tb_tick_rate_controller.sv
// Scoreboard bench for tick_rate_controller: a time-based reference model predicts
// tick events and per-cycle status; a monitor pops and compares on every DUT cycle.
module tb_tick_rate_controller;

  localparam int          CNT_W   = 32;
  localparam int          BURST_W = 8;
  localparam int unsigned DEF_P   = 10000000;

  logic               CLK_in = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic [CNT_W-1:0]   cfg_period;
  logic               cfg_ready;
  logic               start;
  logic               stop;
  logic [BURST_W-1:0] burst_len;
  logic               tick;
  logic               running;
  logic               burst_done;
  logic [CNT_W-1:0]   period_active;
`ifdef SQUARE_OUT_EN
  logic               square_out;
`endif

  tick_rate_controller #(
    .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P), .BURST_W(BURST_W)
  ) dut (
    .CLK_in(CLK_in), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_period(cfg_period), .cfg_ready(cfg_ready),
    .start(start), .stop(stop), .burst_len(burst_len),
    .tick(tick), .running(running), .burst_done(burst_done),
`ifdef SQUARE_OUT_EN
    .square_out(square_out),
`endif
    .period_active(period_active)
  );

  always #5 CLK_in = ~CLK_in;

  typedef struct {
    logic        running;
    logic        burst_done;
    logic        cfg_ready;
    logic [31:0] period;
    logic        square;
  } status_t;

  typedef struct {
    longint      edge_n;
    logic        burst_done;
    logic [31:0] period;
  } tick_t;

  status_t status_q[$];
  tick_t   tick_q[$];
  int      n_compared   = 0;
  int      n_mismatched = 0;

  longint      edge_cnt = 0;
  logic        m_run = 1'b0;
  longint      m_period = DEF_P;
  longint      m_next = 0;
  int          m_remaining = 0;
  logic        m_pend_full = 1'b0;
  logic [31:0] m_pend = '0;
  logic        m_square = 1'b0;
  logic        m_accepted = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  // Reference model: ticks are scheduled as absolute edge numbers, next = now + P + 1.
  initial begin
    logic    acc, m_tick, m_bd;
    status_t s;
    tick_t   t;
    forever begin
      @(posedge CLK_in);
      edge_cnt++;
      m_tick = 1'b0;
      m_bd = 1'b0;
      m_accepted = 1'b0;
      if (reset) begin
        m_run = 1'b0; m_period = DEF_P; m_pend_full = 1'b0;
        m_remaining = 0; m_square = 1'b0;
      end else begin
        acc = cfg_valid && !m_pend_full;
        if (!m_run) begin
          if (m_pend_full) begin m_period = m_pend; m_pend_full = 1'b0; end
          if (start && !stop) begin
            m_run = 1'b1;
            m_remaining = burst_len;
            m_next = edge_cnt + m_period + 1;
          end
        end else if (stop) begin
          m_run = 1'b0;
          m_square = 1'b0;
        end else if (edge_cnt == m_next) begin
          m_tick = 1'b1;
          if (m_pend_full) begin m_period = m_pend; m_pend_full = 1'b0; end
          m_next = edge_cnt + m_period + 1;
          m_square = !m_square;
          if (m_remaining != 0) begin
            if (m_remaining == 1) begin m_bd = 1'b1; m_run = 1'b0; m_square = 1'b0; end
            m_remaining--;
          end
        end
        if (acc) begin m_pend = cfg_period; m_pend_full = 1'b1; m_accepted = 1'b1; end
      end
      s.running = m_run; s.burst_done = m_bd; s.cfg_ready = !m_pend_full;
      s.period = 32'(m_period); s.square = m_square;
      status_q.push_back(s);
      if (m_tick) begin
        t.edge_n = edge_cnt; t.burst_done = m_bd; t.period = 32'(m_period);
        tick_q.push_back(t);
      end
    end
  end

  // Monitor: status every cycle, tick events whenever the DUT pulses or one is overdue.
  initial begin
    status_t s;
    tick_t   t;
    forever begin
      @(negedge CLK_in);
      if (edge_cnt > 0) begin
        checkOutput("status_available", status_q.size() > 0, 1);
        if (status_q.size() > 0) begin
          s = status_q.pop_front();
          checkOutput("running", running, s.running);
          checkOutput("burst_done", burst_done, s.burst_done);
          checkOutput("cfg_ready", cfg_ready, s.cfg_ready);
          checkOutput("period_active", period_active, s.period);
`ifdef SQUARE_OUT_EN
          checkOutput("square_out", square_out, s.square);
`endif
        end
        if (tick === 1'b1) begin
          checkOutput("tick_expected", tick_q.size() > 0, 1);
          if (tick_q.size() > 0) begin
            t = tick_q.pop_front();
            checkOutput("tick_edge", edge_cnt, t.edge_n);
            checkOutput("tick_burst_done", burst_done, t.burst_done);
            checkOutput("tick_period", period_active, t.period);
          end
        end else if (tick_q.size() > 0 && tick_q[0].edge_n <= edge_cnt) begin
          t = tick_q.pop_front();
          checkOutput("tick_missing", tick, 1);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge CLK_in); #1; end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic [BURST_W-1:0] bl);
    start = s; stop = p; burst_len = bl;
    waitCycles(1);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic offerCfg(input logic [CNT_W-1:0] v);
    logic accepted;
    int   n;
    accepted = 1'b0;
    n = 0;
    cfg_valid = 1'b1;
    cfg_period = v;
    while (!accepted && n < 200) begin
      accepted = cfg_ready;
      waitCycles(1);
      n++;
    end
    checkOutput("cfg_accepted", accepted, 1);
    cfg_valid = 1'b0;
  endtask

  task automatic stopOnTick();
    int n;
    n = 0;
    while (edge_cnt != m_next - 1 && n < 200) begin waitCycles(1); n++; end
    checkOutput("stop_aligned", edge_cnt, m_next - 1);
    stop = 1'b1;
    waitCycles(1);
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0;
    start = 1'b0; stop = 1'b0; burst_len = '0;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);

    // Continuous run with P=3
    offerCfg(3); waitCycles(2);
    applyStimulus(1, 0, 0); waitCycles(20);
    applyStimulus(0, 1, 0); waitCycles(3);

    // Burst of 3 with P=2
    offerCfg(2); waitCycles(2);
    applyStimulus(1, 0, 3); waitCycles(15);

    // Mid-interval reconfiguration 5 -> 1
    offerCfg(5); waitCycles(2);
    applyStimulus(1, 0, 0); waitCycles(3);
    offerCfg(1); waitCycles(12);
    applyStimulus(0, 1, 0); waitCycles(3);

    // Stop exactly on a tick edge with a full slot and a second offer held
    offerCfg(4); waitCycles(2);
    applyStimulus(1, 0, 0); waitCycles(2);
    offerCfg(6);
    fork
      offerCfg(2);
      stopOnTick();
    join
    waitCycles(6);

    // Reset mid-burst with pending config
    offerCfg(3); waitCycles(2);
    applyStimulus(1, 0, 10); waitCycles(6);
    cfg_valid = 1'b1; cfg_period = 7; waitCycles(1); cfg_valid = 1'b0;
    reset = 1'b1; waitCycles(1); reset = 1'b0; waitCycles(3);

    // start+stop in IDLE, then start ignored while running
    applyStimulus(1, 1, 0); waitCycles(2);
    offerCfg(1); waitCycles(2);
    applyStimulus(1, 0, 2); waitCycles(1);
    applyStimulus(1, 0, 5); waitCycles(8);

    // P=0 ticks every cycle
    offerCfg(0); waitCycles(2);
    applyStimulus(1, 0, 0); waitCycles(6);
    applyStimulus(0, 1, 0); waitCycles(2);

    // Randomized phase with a holding requester
    for (int i = 0; i < 400; i++) begin
      if (!cfg_valid || m_accepted) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_period = $urandom_range(0, 6);
      end
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 19) == 0);
      burst_len = BURST_W'($urandom_range(0, 4));
      waitCycles(1);
    end
    cfg_valid = 1'b0; start = 1'b0;
    stop = 1'b1; waitCycles(1); stop = 1'b0;
    waitCycles(3);

    checkOutput("tick_queue_drained", tick_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
